// File: rtl/pipe_hazard_ctrl.sv
// RISC15 five-stage pipeline sequencer: PC / pipe-register enables and flushes,
// covering memory wait, taken branch and load-use hazards, plus perf counters.
module pipe_hazard_ctrl #(
  parameter int LOAD_STALL = 1,
  parameter int MAX_WAIT   = 255,
  parameter int CNT_W      = 16,
  parameter int RA_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_is_load,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_we_n,
  output logic             if_id_we_n,
  output logic             id_ex_we_n,
  output logic             ex_mem_we_n,
  output logic             mem_wb_we_n,
  output logic             if_id_nop_n,
  output logic             id_ex_nop_n,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, WAIT = 2'b10} state_t;

  localparam logic [1:0]  BUB_LAST  = 2'(LOAD_STALL - 1);
  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  state_t      state, state_nx;
  logic [1:0]  bub_cnt, bub_nx;
  logic [15:0] wait_cnt, wait_nx;
  logic        lu, flush;

  assign lu = ex_is_load & ((id_use_rs1 & (id_rs1 == ex_rd)) |
                            (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    pc_we_n     = 1'b0;
    if_id_we_n  = 1'b0;
    id_ex_we_n  = 1'b0;
    ex_mem_we_n = 1'b0;
    mem_wb_we_n = 1'b0;
    if_id_nop_n = 1'b1;
    id_ex_nop_n = 1'b1;
    state_nx    = RUN;
    bub_nx      = bub_cnt;
    wait_nx     = '0;
    flush       = 1'b0;
    if (!reset) begin
      {pc_we_n, if_id_we_n, id_ex_we_n, ex_mem_we_n, mem_wb_we_n} = '1;
      if_id_nop_n = 1'b0;
      id_ex_nop_n = 1'b0;
    end else if (mem_busy) begin
      {pc_we_n, if_id_we_n, id_ex_we_n, ex_mem_we_n, mem_wb_we_n} = '1;
      state_nx = WAIT;
      wait_nx  = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
    end else if (branch_taken) begin
      // ID instruction is squashed, so a pending load-use no longer matters
      if_id_nop_n = 1'b0;
      id_ex_nop_n = 1'b0;
      flush       = 1'b1;
    end else if (state == STALL) begin
      pc_we_n     = 1'b1;
      if_id_we_n  = 1'b1;
      id_ex_nop_n = 1'b0;
      bub_nx      = bub_cnt + 2'd1;
      state_nx    = (bub_cnt == BUB_LAST) ? RUN : STALL;
    end else if (lu) begin
      pc_we_n     = 1'b1;
      if_id_we_n  = 1'b1;
      id_ex_nop_n = 1'b0;
      bub_nx      = 2'd1;
      state_nx    = (LOAD_STALL > 1) ? STALL : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      bub_cnt     <= '0;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nx;
      bub_cnt  <= bub_nx;
      wait_cnt <= wait_nx;
      if (mem_busy && (wait_cnt == WAIT_LAST))
        mem_timeout <= 1'b1;
      if (pc_we_n && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (LOAD_STALL 1/2/3, one with 4-bit
// counters) driven in lockstep and compared each cycle against a bubble-count model.
module tb_pipe_hazard_ctrl;
  localparam int N  = 3;
  localparam int MW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, id_use_rs1, id_use_rs2, ex_is_load, branch_taken, mem_busy;
  logic [2:0] id_rs1, id_rs2, ex_rd;

  logic [6:0]  ctl [N];
  logic [15:0] sc  [N];
  logic [15:0] fc  [N];
  logic        tmo [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CW = (g == 2) ? 4 : 16;
    logic [CW-1:0] s, f;
    logic pw, iw, dw, ew, mw, ino, dno, t;
    pipe_hazard_ctrl #(.LOAD_STALL(g + 1), .MAX_WAIT(MW), .CNT_W(CW), .RA_W(3)) u (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_is_load(ex_is_load),
      .ex_rd(ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
      .pc_we_n(pw), .if_id_we_n(iw), .id_ex_we_n(dw), .ex_mem_we_n(ew),
      .mem_wb_we_n(mw), .if_id_nop_n(ino), .id_ex_nop_n(dno),
      .stall_cnt(s), .flush_cnt(f), .mem_timeout(t));
    assign ctl[g] = {pw, iw, dw, ew, mw, ino, dno};
    assign sc[g]  = 16'(s);
    assign fc[g]  = 16'(f);
    assign tmo[g] = t;
  end

  // model: bubbles still owed, consecutive busy cycles, plain-integer counters
  int bl [N], run [N], st [N], fl [N];
  bit to [N];
  int errors = 0, checks = 0;

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] got=%0h want=%0h", tag, i, obs, exp);
    end
  endtask

  function automatic bit lu_now();
    return ex_is_load && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  // drive one cycle's inputs, check at negedge, advance model at posedge
  task automatic step(input bit rst, busy, br, ld, input logic [2:0] r1, r2, rd, input bit u1, u2);
    logic [6:0] e;
    int mx;
    reset = rst; mem_busy = busy; branch_taken = br; ex_is_load = ld;
    id_rs1 = r1; id_rs2 = r2; ex_rd = rd; id_use_rs1 = u1; id_use_rs2 = u2;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!rst)           e = 7'b11111_00;
      else if (busy)      e = 7'b11111_11;
      else if (br)        e = 7'b00000_00;
      else if (bl[i] > 0) e = 7'b11000_10;
      else if (lu_now())  e = 7'b11000_10;
      else                e = 7'b00000_11;
      chk("ctl", i, 32'(ctl[i]), 32'(e));
      chk("stall_cnt", i, 32'(sc[i]), 32'(st[i]));
      chk("flush_cnt", i, 32'(fc[i]), 32'(fl[i]));
      chk("mem_timeout", i, 32'(tmo[i]), 32'(to[i]));
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      mx = (i == 2) ? 15 : 65535;
      if (!rst) begin
        bl[i] = 0; run[i] = 0; st[i] = 0; fl[i] = 0; to[i] = 0;
      end else if (busy) begin
        bl[i] = 0;
        if (run[i] < 65535) run[i]++;
        if (run[i] == MW) to[i] = 1;
        if (st[i] < mx) st[i]++;
      end else begin
        run[i] = 0;
        if (br) begin
          bl[i] = 0;
          if (fl[i] < mx) fl[i]++;
        end else if (bl[i] > 0) begin
          bl[i]--;
          if (st[i] < mx) st[i]++;
        end else if (lu_now()) begin
          bl[i] = i;
          if (st[i] < mx) st[i]++;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      bl[i] = 0; run[i] = 0; st[i] = 0; fl[i] = 0; to[i] = 0;
    end
    reset = 0; mem_busy = 0; branch_taken = 0; ex_is_load = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    @(posedge clk); #1;

    // reset then first free cycle
    do_reset();
    idle(1);

    // load-use on rs1 for one cycle: 1/2/3 bubbles per instance
    step(1, 0, 0, 1, 3'd3, 3'd5, 3'd3, 1, 0);
    idle(3);
    chk("t2_stall_ls1", 0, 32'(sc[0]), 32'd1);
    chk("t3_stall_ls2", 1, 32'(sc[1]), 32'd2);
    chk("t3_stall_ls3", 2, 32'(sc[2]), 32'd3);

    // load-use through rs2 on r0
    step(1, 0, 0, 1, 3'd4, 3'd0, 3'd0, 0, 1);
    idle(3);

    // branch beats load-use
    do_reset();
    step(1, 0, 1, 1, 3'd3, 3'd3, 3'd3, 1, 1);
    idle(1);
    chk("t4_flush", 0, 32'(fc[0]), 32'd1);
    chk("t4_stall", 0, 32'(sc[0]), 32'd0);

    // branch arriving mid-stall aborts remaining bubbles
    step(1, 0, 0, 1, 3'd2, 3'd0, 3'd2, 1, 0);
    step(1, 0, 1, 0, 3'd0, 3'd0, 3'd0, 0, 0);
    idle(2);

    // mem wait swallows a branch; branch honoured once busy drops
    do_reset();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_stall", 0, 32'(sc[0]), 32'd4);
    chk("t5_noflush", 0, 32'(fc[0]), 32'd0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("t5_flush", 0, 32'(fc[0]), 32'd1);

    // timeout: 7 busy edges not enough, 8th sets it, sticky, reset clears
    do_reset();
    for (int k = 0; k < 7; k++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_not_yet", 0, 32'(tmo[0]), 32'd0);
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    chk("t6_sticky", 0, 32'(tmo[0]), 32'd1);
    do_reset();
    chk("t6_cleared", 0, 32'(tmo[0]), 32'd0);

    // random traffic with small register space to hit load-use often
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 1) == 1),
           3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
    end
    // long busy burst then idle: exercises timeout and 4-bit saturation
    for (int k = 0; k < 20; k++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("sat_stall", 2, 32'(sc[2]), 32'd15);
    chk("sat_flush", 2, 32'(fc[2]), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
